// File: rtl/npu_operand_sequencer_if.sv
// Bundle of the operand write port, run/status signals and the core
// start/done handshake between a controller (master) and the operand
// sequencer (slave).
interface npu_operand_sequencer_if #(
    parameter int DEPTH = 4
);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic               wr_valid;
    logic [7:0]         wr_data;
    logic               wr_ready;
    logic               run;
    logic               busy;
    logic [LEVEL_W-1:0] level;
    logic               core_start;
    logic [3:0]         core_input;
    logic [3:0]         core_weight;
    logic               core_done;
    logic [3:0]         core_result;
    logic [7:0]         acc_out;
    logic               done;
    logic               error;

    modport master (
        output wr_valid, wr_data, run, core_done, core_result,
        input  wr_ready, busy, level, core_start, core_input, core_weight,
               acc_out, done, error
    );

    modport slave (
        input  wr_valid, wr_data, run, core_done, core_result,
        output wr_ready, busy, level, core_start, core_input, core_weight,
               acc_out, done, error
    );
endinterface

// File: rtl/npu_operand_sequencer.sv
// Operand sequencer for the NPU core: buffers 4-bit input/weight pairs in a
// small circular buffer, issues them one at a time to the core on a run
// command, accumulates the core results and guards each wait with a watchdog.
module npu_operand_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    npu_operand_sequencer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [7:0]       WD_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t           state_r;
    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [7:0]       wd_r;
    logic             core_start_r;
    logic [3:0]       core_input_r;
    logic [3:0]       core_weight_r;
    logic [7:0]       acc_r;
    logic             done_r;
    logic             error_r;
    logic             busy_r;

    logic             full_s;
    logic             wr_ready_s;
    logic             wr_accept_s;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [7:0]       head_s;
    logic [7:0]       next_head_s;

    // Input operand lives in the low nibble of a buffer entry.
    function automatic logic [3:0] op_input(input logic [7:0] entry);
        return entry[3:0];
    endfunction

    // Weight operand lives in the high nibble of a buffer entry.
    function automatic logic [3:0] op_weight(input logic [7:0] entry);
        return entry[7:4];
    endfunction

    // Core results are unsigned; widen to accumulator width.
    function automatic logic [7:0] zext_result(input logic [3:0] res);
        return {4'b0000, res};
    endfunction

    // Write acceptance and head-of-buffer selection.
    always_comb begin
        full_s = (count_r == CNT_FULL);
        if ((state_r == ST_IDLE) && !full_s && !bus.run) begin
            wr_ready_s = 1'b1;
        end else begin
            wr_ready_s = 1'b0;
        end
        wr_accept_s   = bus.wr_valid && wr_ready_s;
        rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        head_s        = mem_r[rd_ptr_r];
        next_head_s   = mem_r[rd_ptr_next_s];
    end

    // Operand storage: capture accepted writes at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (wr_accept_s) begin
            mem_r[wr_ptr_r] <= bus.wr_data;
        end
    end

    // Sequencer FSM with buffer bookkeeping, watchdog and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            wd_r          <= 8'd0;
            core_start_r  <= 1'b0;
            core_input_r  <= 4'd0;
            core_weight_r <= 4'd0;
            acc_r         <= 8'd0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            core_start_r <= 1'b0;
            done_r       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.run) begin
                        acc_r   <= 8'd0;
                        error_r <= 1'b0;
                        busy_r  <= 1'b1;
                        if (count_r != '0) begin
                            core_input_r  <= op_input(head_s);
                            core_weight_r <= op_weight(head_s);
                            core_start_r  <= 1'b1;
                            state_r       <= ST_ISSUE;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= ST_FINISH;
                        end
                    end else if (wr_accept_s) begin
                        wr_ptr_r <= wr_ptr_r + PTR_ONE;
                        count_r  <= count_r + CNT_ONE;
                    end
                end
                ST_ISSUE: begin
                    wd_r    <= 8'd0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.core_done) begin
                        acc_r    <= acc_r + zext_result(bus.core_result);
                        count_r  <= count_r - CNT_ONE;
                        rd_ptr_r <= rd_ptr_next_s;
                        if (count_r > CNT_ONE) begin
                            core_input_r  <= op_input(next_head_s);
                            core_weight_r <= op_weight(next_head_s);
                            core_start_r  <= 1'b1;
                            state_r       <= ST_ISSUE;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= ST_FINISH;
                        end
                    end else if (wd_r == WD_LAST) begin
                        // Core is stuck: drop the remaining operands, keep partial sum.
                        error_r  <= 1'b1;
                        count_r  <= '0;
                        rd_ptr_r <= wr_ptr_r;
                        done_r   <= 1'b1;
                        state_r  <= ST_FINISH;
                    end else begin
                        wd_r <= wd_r + 8'd1;
                    end
                end
                ST_FINISH: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wr_ready    = wr_ready_s;
    assign bus.busy        = busy_r;
    assign bus.level       = count_r;
    assign bus.core_start  = core_start_r;
    assign bus.core_input  = core_input_r;
    assign bus.core_weight = core_weight_r;
    assign bus.acc_out     = acc_r;
    assign bus.done        = done_r;
    assign bus.error       = error_r;
endmodule

// File: tb/tb_npu_operand_sequencer.sv
// Directed self-checking bench for npu_operand_sequencer (DEPTH=4, TIMEOUT=15).
module tb_npu_operand_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    npu_operand_sequencer_if #(.DEPTH(4)) bus_if ();

    npu_operand_sequencer #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Core stand-in: auto mode answers input+weight two cycles after start.
    logic       core_auto  = 1'b0;
    logic       model_done = 1'b0;
    logic [3:0] model_res  = 4'd0;
    logic [3:0] model_next = 4'd0;
    int         model_cd   = 0;
    logic       man_done   = 1'b0;
    logic [3:0] man_res    = 4'd0;

    assign bus_if.core_done   = model_done | man_done;
    assign bus_if.core_result = model_done ? model_res : man_res;

    always @(posedge clk) begin
        #1;
        model_done = 1'b0;
        if (core_auto) begin
            if (model_cd > 0) begin
                model_cd = model_cd - 1;
                if (model_cd == 0) begin
                    model_done = 1'b1;
                    model_res  = model_next;
                end
            end
            if (bus_if.core_start === 1'b1) begin
                model_cd   = 2;
                model_next = bus_if.core_input + bus_if.core_weight;
            end
        end else begin
            model_cd = 0;
        end
    end

    // Monitor: count start/done pulses and log issued operands.
    int         start_cnt = 0;
    int         done_cnt  = 0;
    logic [3:0] seen_in [8];
    logic [3:0] seen_w  [8];

    always @(negedge clk) begin
        if (bus_if.core_start === 1'b1) begin
            if (start_cnt < 8) begin
                seen_in[start_cnt[2:0]] = bus_if.core_input;
                seen_w[start_cnt[2:0]]  = bus_if.core_weight;
            end
            start_cnt = start_cnt + 1;
        end
        if (bus_if.done === 1'b1) begin
            done_cnt = done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run = tests_run + 1;
        assert (obs === exp) else begin
            tests_failed = tests_failed + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        bus_if.wr_valid = 1'b1;
        bus_if.wr_data  = b;
        step(1);
        bus_if.wr_valid = 1'b0;
    endtask

    int base_s;
    int base_d;

    initial begin
        bus_if.wr_valid = 1'b0;
        bus_if.wr_data  = 8'h00;
        bus_if.run      = 1'b0;

        // Reset state
        rst_n = 1'b0;
        step(2);
        chk("rst_core_start", bus_if.core_start, 1'b0);
        chk("rst_core_input", bus_if.core_input, 4'd0);
        chk("rst_core_weight", bus_if.core_weight, 4'd0);
        chk("rst_acc", bus_if.acc_out, 8'd0);
        chk("rst_done", bus_if.done, 1'b0);
        chk("rst_error", bus_if.error, 1'b0);
        chk("rst_busy", bus_if.busy, 1'b0);
        chk("rst_level", bus_if.level, 3'd0);
        rst_n = 1'b1;
        step(1);
        chk("rst_wr_ready", bus_if.wr_ready, 1'b1);

        // Four operand pairs, then an overflow attempt on the full buffer
        wr(8'h23);
        chk("lvl_after_1", bus_if.level, 3'd1);
        wr(8'h45);
        wr(8'h67);
        wr(8'hF1);
        chk("lvl_full", bus_if.level, 3'd4);
        bus_if.wr_valid = 1'b1;
        bus_if.wr_data  = 8'h99;
        @(negedge clk);
        chk("full_wr_ready", bus_if.wr_ready, 1'b0);
        step(1);
        bus_if.wr_valid = 1'b0;
        chk("full_no_overwrite_lvl", bus_if.level, 3'd4);

        // Run with L=2 core: results 5,9,13,0 -> 27
        base_s    = start_cnt;
        base_d    = done_cnt;
        core_auto = 1'b1;
        bus_if.run = 1'b1;
        step(1);
        bus_if.run = 1'b0;
        chk("r1_c1_start", bus_if.core_start, 1'b1);
        chk("r1_c1_input", bus_if.core_input, 4'd3);
        chk("r1_c1_weight", bus_if.core_weight, 4'd2);
        chk("r1_c1_busy", bus_if.busy, 1'b1);
        step(3);
        chk("r1_c4_level", bus_if.level, 3'd3);
        chk("r1_c4_acc", bus_if.acc_out, 8'd5);
        chk("r1_c4_start", bus_if.core_start, 1'b1);
        chk("r1_c4_input", bus_if.core_input, 4'd5);
        chk("r1_c4_weight", bus_if.core_weight, 4'd4);
        step(8);
        chk("r1_c12_done", bus_if.done, 1'b0);
        chk("r1_c12_level", bus_if.level, 3'd1);
        step(1);
        chk("r1_c13_done", bus_if.done, 1'b1);
        chk("r1_c13_acc", bus_if.acc_out, 8'd27);
        chk("r1_c13_level", bus_if.level, 3'd0);
        chk("r1_c13_error", bus_if.error, 1'b0);
        step(1);
        chk("r1_c14_done", bus_if.done, 1'b0);
        chk("r1_c14_busy", bus_if.busy, 1'b0);
        chk("r1_c14_acc_hold", bus_if.acc_out, 8'd27);
        chk("r1_starts", start_cnt - base_s, 4);
        chk("r1_dones", done_cnt - base_d, 1);
        chk("r1_op3_in", seen_in[2], 4'd7);
        chk("r1_op3_w", seen_w[2], 4'd6);
        chk("r1_op4_in", seen_in[3], 4'd1);
        chk("r1_op4_w", seen_w[3], 4'd15);

        // Empty run
        base_s = start_cnt;
        bus_if.run = 1'b1;
        step(1);
        bus_if.run = 1'b0;
        chk("empty_done", bus_if.done, 1'b1);
        chk("empty_acc", bus_if.acc_out, 8'd0);
        chk("empty_start", bus_if.core_start, 1'b0);
        step(1);
        chk("empty_done_drop", bus_if.done, 1'b0);
        chk("empty_no_start", start_cnt - base_s, 0);

        // Watchdog: core never answers
        core_auto = 1'b0;
        wr(8'h34);
        wr(8'h11);
        chk("to_level", bus_if.level, 3'd2);
        bus_if.run = 1'b1;
        step(1);
        bus_if.run = 1'b0;
        chk("to_start", bus_if.core_start, 1'b1);
        chk("to_input", bus_if.core_input, 4'd4);
        chk("to_weight", bus_if.core_weight, 4'd3);
        step(15);
        chk("to_c16_done", bus_if.done, 1'b0);
        chk("to_c16_error", bus_if.error, 1'b0);
        step(1);
        chk("to_c17_done", bus_if.done, 1'b1);
        chk("to_c17_error", bus_if.error, 1'b1);
        chk("to_c17_level", bus_if.level, 3'd0);
        chk("to_c17_acc", bus_if.acc_out, 8'd0);
        step(1);
        chk("to_error_sticky", bus_if.error, 1'b1);
        chk("to_idle_busy", bus_if.busy, 1'b0);
        chk("to_idle_wr_ready", bus_if.wr_ready, 1'b1);
        bus_if.run = 1'b1;
        step(1);
        bus_if.run = 1'b0;
        chk("to_error_cleared", bus_if.error, 1'b0);
        chk("to_rerun_done", bus_if.done, 1'b1);
        step(1);

        // Buffer usable after flush: 0x52 -> 2+5 = 7
        core_auto = 1'b1;
        wr(8'h52);
        bus_if.run = 1'b1;
        step(1);
        bus_if.run = 1'b0;
        chk("flush_input", bus_if.core_input, 4'd2);
        chk("flush_weight", bus_if.core_weight, 4'd5);
        step(3);
        chk("flush_done", bus_if.done, 1'b1);
        chk("flush_acc", bus_if.acc_out, 8'd7);
        step(1);

        // Spurious done in IDLE
        core_auto = 1'b0;
        man_done  = 1'b1;
        man_res   = 4'hF;
        step(1);
        man_done = 1'b0;
        chk("sp_idle_acc", bus_if.acc_out, 8'd7);
        chk("sp_idle_busy", bus_if.busy, 1'b0);
        wr(8'h21);
        chk("sp_level", bus_if.level, 3'd1);
        bus_if.run = 1'b1;
        step(1);
        bus_if.run = 1'b0;
        chk("sp_issue_start", bus_if.core_start, 1'b1);
        // Spurious done in ISSUE
        man_done = 1'b1;
        man_res  = 4'hF;
        step(1);
        man_done = 1'b0;
        chk("sp_issue_acc", bus_if.acc_out, 8'd0);
        chk("sp_issue_level", bus_if.level, 3'd1);
        // run and write during WAIT
        bus_if.run      = 1'b1;
        bus_if.wr_valid = 1'b1;
        bus_if.wr_data  = 8'h44;
        @(negedge clk);
        chk("sp_wait_wr_ready", bus_if.wr_ready, 1'b0);
        step(1);
        bus_if.run      = 1'b0;
        bus_if.wr_valid = 1'b0;
        chk("sp_wait_level", bus_if.level, 3'd1);
        chk("sp_wait_busy", bus_if.busy, 1'b1);
        man_done = 1'b1;
        man_res  = 4'd3;
        step(1);
        man_done = 1'b0;
        chk("sp_done", bus_if.done, 1'b1);
        chk("sp_acc", bus_if.acc_out, 8'd3);
        chk("sp_level0", bus_if.level, 3'd0);
        step(1);
        chk("sp_idle_after", bus_if.busy, 1'b0);
        chk("sp_acc_hold", bus_if.acc_out, 8'd3);

        // wr_valid and run together in IDLE: run wins
        bus_if.wr_valid = 1'b1;
        bus_if.wr_data  = 8'h77;
        bus_if.run      = 1'b1;
        @(negedge clk);
        chk("both_wr_ready", bus_if.wr_ready, 1'b0);
        step(1);
        bus_if.wr_valid = 1'b0;
        bus_if.run      = 1'b0;
        chk("both_level", bus_if.level, 3'd0);
        chk("both_done", bus_if.done, 1'b1);
        chk("both_acc", bus_if.acc_out, 8'd0);
        step(1);

        // Reset during WAIT of second entry
        core_auto = 1'b1;
        wr(8'h11);
        wr(8'h22);
        bus_if.run = 1'b1;
        step(1);
        bus_if.run = 1'b0;
        step(4);
        chk("mr_busy", bus_if.busy, 1'b1);
        chk("mr_level", bus_if.level, 3'd1);
        chk("mr_input", bus_if.core_input, 4'd2);
        base_d = done_cnt;
        rst_n  = 1'b0;
        #1;
        chk("mr_rst_busy", bus_if.busy, 1'b0);
        chk("mr_rst_level", bus_if.level, 3'd0);
        chk("mr_rst_acc", bus_if.acc_out, 8'd0);
        chk("mr_rst_input", bus_if.core_input, 4'd0);
        chk("mr_rst_weight", bus_if.core_weight, 4'd0);
        chk("mr_rst_start", bus_if.core_start, 1'b0);
        chk("mr_rst_done", bus_if.done, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(6);
        chk("mr_no_done", done_cnt - base_d, 0);
        chk("mr_post_busy", bus_if.busy, 1'b0);
        chk("mr_post_level", bus_if.level, 3'd0);
        chk("mr_post_wr_ready", bus_if.wr_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/npu_operand_sequencer.md
# npu_operand_sequencer

Upstream feeder for the NPU core. Buffers up to DEPTH 4-bit input/weight operand pairs written over a byte-wide valid/ready port. On a `run` command it issues them one at a time to the core through the core's start/done handshake. It sums the 4-bit core results into an 8-bit accumulator and reports completion, with a watchdog against a core that never signals done.

## Interface
- DEPTH, 4, operand buffer entries; power of two, 2..16 (16×15 = 240 fits 8 bits, no overflow possible)
- TIMEOUT, 15, max cycles waiting for `core_done` after a start before abort; 1..255
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- wr_valid  input  1  operand write request
- wr_data  input  8  {weight[3:0], input[3:0]}; bits 7:4 weight, 3:0 input
- wr_ready  output  1  write accepted when wr_valid && wr_ready; combinational: IDLE && !full && !run
- run  input  1  start processing buffered operands; sampled only in IDLE
- busy  output  1  high in ISSUE/WAIT/FINISH
- level  output  clog2(DEPTH)+1  entries currently buffered
- core_start  output  1  one-cycle start pulse to core
- core_input  output  4  operand input to core, held stable ISSUE through WAIT
- core_weight  output  4  operand weight to core, held stable ISSUE through WAIT
- core_done  input  1  core completion pulse
- core_result  input  4  core result, valid when core_done
- acc_out  output  8  sum of results of last run
- done  output  1  one-cycle pulse at end of run
- error  output  1  sticky watchdog flag; cleared when next run accepted

## Operation
- Buffer: circular, wr_ptr/rd_ptr mod DEPTH, count 0..DEPTH; write pushes at wr_ptr; pop on accepted core_done.
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE: writes accepted while not full. `run` high: clear acc_out and error. If count>0, load core_input/core_weight from head entry → ISSUE; if count==0 → FINISH.
- ISSUE (1 cycle): core_start=1; clear watchdog → WAIT.
- WAIT: watchdog increments each cycle. On core_done: acc_out += zero-extended core_result, pop. If entries remain, load next head operands → ISSUE, else → FINISH. If watchdog reaches TIMEOUT without core_done: error=1, flush buffer (count=0, rd_ptr=wr_ptr), acc_out holds partial sum → FINISH.
- FINISH (1 cycle): done=1 → IDLE.
- core_done outside WAIT: ignored. `run` outside IDLE: ignored. Writes outside IDLE: refused (wr_ready=0).
- Simultaneous wr_valid and run in IDLE: run wins, write not accepted (wr_ready=0 that cycle).
- Full buffer: wr_ready=0; no overwrite.

## Timing
- Reset values: core_start 0, core_input 0, core_weight 0, acc_out 0, done 0, error 0, busy 0, level 0, state IDLE; wr_ready 1 once reset released (combinational).
- Reset mid-run: immediate abort, buffer emptied, no done pulse.
- Run accepted cycle 0 → core_start high cycle 1. core_done in cycle k → acc_out/level updated cycle k+1. The next core_start (if any) is in cycle k+1, else done in cycle k+1.
- Per entry with core latency L (done L cycles after start): L+1 cycles. Total run = 1 + N·(L+1) cycles to done, plus 1 for FINISH.
- Empty run: done pulses cycle 1, acc_out=0, no core_start.
- Timeout: core_start at cycle s, no done → error and FINISH at cycle s+TIMEOUT+1, done at that cycle.
- acc_out stable from done until next run acceptance.
- level updates cycle after write accept/pop.

## Test plan
- Write 4 pairs 0x23,0x45,0x67,0xF1, run, core model L=2 returning input+weight mod 16 (5,9,13,0) → 4 core_start pulses with matching operands; done once; acc_out=27; level 0; error 0.
- Fill DEPTH=4, assert wr_valid a 5th time → wr_ready=0, level stays 4; run consumes exactly 4 entries.
- Run with empty buffer → done at cycle 1, acc_out=0, no core_start.
- Core never asserts done, TIMEOUT=15 → error=1 and done 16 cycles after core_start; level 0; next run clears error.
- Spurious core_done in IDLE and ISSUE, run pulsed during WAIT, wr_valid+run same cycle in IDLE → all ignored; write refused; results unchanged.
- Assert rst_n low during WAIT of 2nd entry → all outputs to reset values immediately; level 0; no done pulse after release.
